// File: rtl/pulse_shift_config_loader_if.sv
// Host-side and serial-side signal bundle for the pulse shift config loader.
// master: host/bench drives delay selects and load; slave: the loader.
interface pulse_shift_config_loader_if;
  logic [4:0] inDelayX;
  logic [4:0] inDelayY;
  logic       inLoad;
  logic       outDataClock;
  logic       outData;
  logic       outBusy;
  logic       outDone;
  logic [4:0] outLoadedX;
  logic [4:0] outLoadedY;
  logic       outLoadedValid;

  modport master (
    output inDelayX, inDelayY, inLoad,
    input  outDataClock, outData, outBusy, outDone,
    input  outLoadedX, outLoadedY, outLoadedValid
  );

  modport slave (
    input  inDelayX, inDelayY, inLoad,
    output outDataClock, outData, outBusy, outDone,
    output outLoadedX, outLoadedY, outLoadedValid
  );
endinterface

// File: rtl/pulse_shift_config_loader.sv
// Shifts a 10-bit {Y,X} delay word LSB-first on a generated serial clock.
// Ports: Clock, nReset (async low), bus (slave: load in, serial/status out).
module pulse_shift_config_loader #(
  parameter int CLK_DIV = 4
) (
  input  logic Clock,
  input  logic nReset,
  pulse_shift_config_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_t;

  localparam logic [7:0] PhLast  = 8'(CLK_DIV - 1);
  localparam logic [3:0] BitLast = 4'd9;

  state_t     state;
  logic [7:0] phaseCnt;
  logic [3:0] bitCnt;
  logic [9:0] frameWord;
  logic [9:0] pendWord;
  logic       pendValid;

  logic [9:0] inWord;
  logic       phaseEnd;
  logic [3:0] nextBit;

  assign inWord   = {bus.inDelayY, bus.inDelayX};
  assign phaseEnd = (phaseCnt == PhLast);
  assign nextBit  = bitCnt + 4'd1;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state              <= IDLE;
      phaseCnt           <= '0;
      bitCnt             <= '0;
      frameWord          <= '0;
      pendWord           <= '0;
      pendValid          <= 1'b0;
      bus.outDataClock   <= 1'b0;
      bus.outData        <= 1'b0;
      bus.outBusy        <= 1'b0;
      bus.outDone        <= 1'b0;
      bus.outLoadedX     <= '0;
      bus.outLoadedY     <= '0;
      bus.outLoadedValid <= 1'b0;
    end else begin
      bus.outDone <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.inLoad) begin
            frameWord   <= inWord;
            bus.outData <= inWord[0];
            bus.outBusy <= 1'b1;
            phaseCnt    <= '0;
            bitCnt      <= '0;
            state       <= LOW;
          end
        end
        LOW: begin
          if (bus.inLoad) begin
            pendWord  <= inWord;
            pendValid <= 1'b1;
          end
          if (phaseEnd) begin
            phaseCnt         <= '0;
            bus.outDataClock <= 1'b1;
            state            <= HIGH;
          end else begin
            phaseCnt <= phaseCnt + 8'd1;
          end
        end
        HIGH: begin
          if (bus.inLoad) begin
            pendWord  <= inWord;
            pendValid <= 1'b1;
          end
          if (phaseEnd) begin
            phaseCnt         <= '0;
            bus.outDataClock <= 1'b0;
            state            <= LOW;
            if (bitCnt == BitLast) begin
              bus.outDone        <= 1'b1;
              bus.outLoadedX     <= frameWord[4:0];
              bus.outLoadedY     <= frameWord[9:5];
              bus.outLoadedValid <= 1'b1;
              bitCnt             <= '0;
              // A load on the completion edge is newer than the slot.
              pendValid          <= 1'b0;
              if (bus.inLoad) begin
                frameWord   <= inWord;
                bus.outData <= inWord[0];
              end else if (pendValid) begin
                frameWord   <= pendWord;
                bus.outData <= pendWord[0];
              end else begin
                bus.outBusy <= 1'b0;
                bus.outData <= 1'b0;
                state       <= IDLE;
              end
            end else begin
              bitCnt      <= nextBit;
              bus.outData <= frameWord[nextBit];
            end
          end else begin
            phaseCnt <= phaseCnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_shift_config_loader.sv
// Scoreboard bench: CLK_DIV=2 instance for functional cases,
// CLK_DIV=255 instance for the max-divider continuous-load case.
module tb_pulse_shift_config_loader;

  localparam int DA = 2;
  localparam int DB = 255;

  typedef struct {
    logic [9:0] w;
    int         doneCyc;
  } exp_t;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  int   cyc = 0;

  int nCmp = 0;
  int nFail = 0;

  exp_t qA[$];
  int   qB[$];

  logic [9:0] rxA = '0;
  int   edgesA = 0;
  int   edgeTotalA = 0;
  logic prevA = 1'b0;
  int   edgesB = 0;
  logic prevB = 1'b0;

  pulse_shift_config_loader_if ifA ();
  pulse_shift_config_loader_if ifB ();

  pulse_shift_config_loader #(.CLK_DIV(DA)) dutA (
    .Clock (clk),
    .nReset(nReset),
    .bus   (ifA.slave)
  );

  pulse_shift_config_loader #(.CLK_DIV(DB)) dutB (
    .Clock (clk),
    .nReset(nReset),
    .bus   (ifB.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor A: receiver model shifts right from bit 9 on each rising edge.
  always @(negedge clk) begin
    if (ifA.outDataClock && !prevA) begin
      edgeTotalA++;
      edgesA++;
      rxA = {ifA.outData, rxA[9:1]};
    end
    prevA = ifA.outDataClock;
    if (!nReset) begin
      edgesA = 0;
      rxA = '0;
    end else if (ifA.outDone) begin
      if (qA.size() == 0) begin
        check("A_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qA.pop_front();
        check("A_rx_word", 32'(rxA), 32'(e.w));
        check("A_loadedX", 32'(ifA.outLoadedX), 32'(e.w[4:0]));
        check("A_loadedY", 32'(ifA.outLoadedY), 32'(e.w[9:5]));
        check("A_loadedValid", 32'(ifA.outLoadedValid), 32'd1);
        check("A_edges", 32'(edgesA), 32'd10);
        check("A_done_cycle", 32'(cyc), 32'(e.doneCyc));
      end
      edgesA = 0;
    end
  end

  always @(negedge clk) begin
    if (ifB.outDataClock && !prevB) edgesB++;
    prevB = ifB.outDataClock;
    if (!nReset) begin
      edgesB = 0;
    end else if (ifB.outDone) begin
      if (qB.size() == 0) begin
        check("B_unexpected_done", 32'd1, 32'd0);
      end else begin
        int d;
        d = qB.pop_front();
        check("B_done_cycle", 32'(cyc), 32'(d));
        check("B_edges", 32'(edgesB), 32'd10);
        check("B_loaded", 32'({ifB.outLoadedY, ifB.outLoadedX}),
              32'({5'd31, 5'd0}));
        check("B_loadedValid", 32'(ifB.outLoadedValid), 32'd1);
      end
      edgesB = 0;
    end
  end

  task automatic driveA(input logic [4:0] x, input logic [4:0] y,
                        output int t);
    @(negedge clk);
    ifA.inDelayX = x;
    ifA.inDelayY = y;
    ifA.inLoad = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    ifA.inLoad = 1'b0;
  endtask

  task automatic waitCyc(input int target);
    int n;
    n = 0;
    while (cyc < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drainA(input string nm);
    int n;
    n = 0;
    while ((qA.size() != 0 || ifA.outBusy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(qA.size()), 32'd0);
  endtask

  initial begin
    int t;
    int idleSeen;
    int snap;
    ifA.inDelayX = '0;
    ifA.inDelayY = '0;
    ifA.inLoad = 1'b0;
    ifB.inDelayX = '0;
    ifB.inDelayY = '0;
    ifB.inLoad = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs_A", 32'({ifA.outDataClock, ifA.outData,
          ifA.outBusy, ifA.outDone, ifA.outLoadedX, ifA.outLoadedY,
          ifA.outLoadedValid}), 32'd0);
    nReset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_release", 32'({ifA.outDataClock, ifA.outBusy,
          ifB.outDataClock, ifB.outBusy}), 32'd0);

    // Single load: X=3, Y=17
    driveA(5'd3, 5'd17, t);
    qA.push_back('{10'b1000100011, t + 20 * DA});
    check("busy_after_accept", 32'(ifA.outBusy), 32'd1);
    drainA("drain_single");

    // Coalescing: 1/1 then 5/6 and 31/0 while busy
    driveA(5'd1, 5'd1, t);
    qA.push_back('{{5'd1, 5'd1}, t + 20 * DA});
    qA.push_back('{{5'd0, 5'd31}, t + 40 * DA});
    idleSeen = 0;
    while (cyc < t + 40 * DA - 1) begin
      if (cyc == t + 5) begin
        ifA.inDelayX = 5'd5;
        ifA.inDelayY = 5'd6;
        ifA.inLoad = 1'b1;
      end else if (cyc == t + 10) begin
        ifA.inDelayX = 5'd31;
        ifA.inDelayY = 5'd0;
        ifA.inLoad = 1'b1;
      end else begin
        ifA.inLoad = 1'b0;
      end
      @(negedge clk);
      if (!ifA.outBusy) idleSeen++;
    end
    ifA.inLoad = 1'b0;
    check("coalesce_busy_continuous", 32'(idleSeen), 32'd0);
    drainA("drain_coalesce");

    // Load asserted on the completion edge itself
    driveA(5'd2, 5'd9, t);
    qA.push_back('{{5'd9, 5'd2}, t + 20 * DA});
    qA.push_back('{{5'd20, 5'd7}, t + 40 * DA});
    waitCyc(t + 20 * DA - 1);
    ifA.inDelayX = 5'd7;
    ifA.inDelayY = 5'd20;
    ifA.inLoad = 1'b1;
    @(negedge clk);
    ifA.inLoad = 1'b0;
    check("done_edge_busy", 32'({ifA.outDone, ifA.outBusy,
          ifA.outDataClock, ifA.outData}), 32'({1'b1, 1'b1, 1'b0, 1'b1}));
    drainA("drain_done_edge");

    // Reset after bit 4's rising edge
    driveA(5'd4, 5'd4, t);
    waitCyc(t + 9 * DA + 1);
    check("midframe_clk_high", 32'(ifA.outDataClock), 32'd1);
    #2 nReset = 1'b0;
    #1;
    check("midframe_reset_outs", 32'({ifA.outDataClock, ifA.outData,
          ifA.outBusy, ifA.outDone, ifA.outLoadedX, ifA.outLoadedY,
          ifA.outLoadedValid}), 32'd0);
    snap = edgeTotalA;
    repeat (3) @(negedge clk);
    nReset = 1'b1;
    repeat (4) @(negedge clk);
    check("no_edge_across_reset", 32'(edgeTotalA), 32'(snap));
    check("idle_after_midframe", 32'({ifA.outBusy, ifA.outLoadedValid}),
          32'd0);
    driveA(5'd10, 5'd21, t);
    qA.push_back('{{5'd21, 5'd10}, t + 20 * DA});
    drainA("drain_after_reset");

    // Max divider, load held high across two frames
    @(negedge clk);
    ifB.inDelayX = 5'd0;
    ifB.inDelayY = 5'd31;
    ifB.inLoad = 1'b1;
    t = cyc + 1;
    qB.push_back(t + 20 * DB);
    qB.push_back(t + 40 * DB);
    waitCyc(t + DB - 1);
    check("B_low_phase", 32'({ifB.outDataClock, ifB.outBusy}), 32'b01);
    @(negedge clk);
    check("B_first_rise", 32'(ifB.outDataClock), 32'd1);
    waitCyc(t + 2 * DB - 1);
    check("B_high_phase", 32'(ifB.outDataClock), 32'd1);
    @(negedge clk);
    check("B_first_fall", 32'(ifB.outDataClock), 32'd0);
    waitCyc(t + 20 * DB);
    ifB.inLoad = 1'b0;
    check("B_busy_at_done", 32'({ifB.outDone, ifB.outBusy}), 32'b11);
    waitCyc(t + 40 * DB + 5);
    check("B_queue_empty", 32'(qB.size()), 32'd0);
    check("B_idle_end", 32'(ifB.outBusy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
    $finish;
  end

endmodule
